fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Fetch-stage sequencer. It owns the architectural fetch PC and drives the instruction-bus request/response handshake. It holds one fetched instruction in an output buffer that feeds the fetch/decode register, and it handles stalls from decode plus redirects (branch/jump/exception) from later stages. This includes discarding responses to in-flight requests that a redirect has made stale.

Parameters:
RESET_PC, 32'hbfc0_0000, fetch PC loaded on reset.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
ireq_valid  out  1  instruction fetch request.
ireq_addr  out  32  fetch address (word aligned).
iresp_data_ok  in  1  response valid; completes the outstanding request.
iresp_data  in  32  instruction word, valid with iresp_data_ok.
redirect_valid  in  1  redirect the PC (branch, jump or exception).
redirect_pc  in  32  redirect target.
stall  in  1  decode cannot accept the buffered instruction this cycle.
out_valid  out  1  output buffer holds a valid instruction.
out_pc  out  32  PC of the buffered instruction.
out_pc_plus_4  out  32  out_pc + 4, modulo 2^32.
out_instr  out  32  buffered instruction word.
out_adel  out  1  buffered entry is an address-error (misaligned PC) bubble.

Behaviour:
- Reset (asynchronous) values:
  - pc = RESET_PC; state = RUN; pending = 0; out_valid = 0; out_adel = 0.
  - out_pc = 0; out_instr = 0; ireq_valid = 0 while reset is high.
- States:
  - RUN: normal fetch.
  - DISCARD: a stale request is still in flight.
  - HALT: stopped after a misaligned PC; waits for a redirect.
- consume = out_valid & !stall. The buffer is emptied at a clock edge where consume is 1.
- Bus rule: once ireq_valid is asserted, ireq_valid and ireq_addr stay stable until the cycle in which iresp_data_ok = 1.
  - iresp_data_ok may arrive in the same cycle as the request (zero wait) or any later cycle.
  - pending = 1 while a request is outstanding and un-acked at the end of a cycle.
- RUN with pc[1:0] == 0:
  - ireq_valid = pending | !out_valid | !stall; ireq_addr = pc.
  - On iresp_data_ok without redirect: out_pc <= pc, out_instr <= iresp_data, out_valid <= 1, out_adel <= 0, pc <= pc + 4 (wraps), pending <= 0.
  - Fetch-to-output latency is 1 cycle after iresp_data_ok.
  - Sustained throughput is 1 instruction per cycle with zero-wait bus and no stall.
- RUN with pc[1:0] != 0:
  - No bus request is made.
  - When the buffer is free or being consumed: out_valid <= 1, out_adel <= 1, out_instr <= 0, out_pc <= pc; then enter HALT.
- HALT: ireq_valid = 0. The buffer drains normally. Only a redirect leaves HALT.
- Buffer without a new fill: when consume is 1 and no response is written, out_valid <= 0.
- Redirect (highest priority, any state):
  - pc <= redirect_pc; out_valid <= 0 (buffered entry flushed even if stalled).
  - If a request is outstanding or issued this cycle and iresp_data_ok = 0: enter DISCARD.
  - If iresp_data_ok = 1 this cycle: drop the data and enter RUN.
  - Otherwise: enter RUN.
- DISCARD:
  - ireq_valid = 1 with the old address held stable.
  - On iresp_data_ok: drop the data, pending <= 0, go to RUN. The new pc is fetched from the next cycle.
  - A further redirect in DISCARD only overwrites pc.
- Simultaneous redirect and stall: the redirect wins and the buffer is flushed.
- Reset mid-request: all state is cleared and the stale response is not expected (the bus is reset too).

Test Plan:
- Zero-wait stream: reset released, data_ok = 1 every cycle with the request, stall = 0 -> out_pc = bfc00000, bfc00004, bfc00008 on consecutive cycles, out_pc_plus_4 = out_pc + 4.
- Wait states: data_ok 3 cycles late -> ireq_addr stays bfc00000 for all 3 cycles, out_valid rises 1 cycle after data_ok.
- Stall: stall = 1 for 4 cycles with the buffer full -> no new request issued, out_instr unchanged; when stall drops, the next fetch goes to bfc00004.
- Redirect in flight: request to bfc00004 pending, redirect_pc = 80001000 -> addr held until data_ok, response dropped (out_valid = 0), next request at 80001000.
- Redirect and data_ok in the same cycle -> data dropped, next ireq_addr = target.
- Misaligned: redirect_pc = 80000002 -> no request; out_adel = 1, out_pc = 80000002; HALT until redirect to 80000000 resumes fetching.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the fetch PC, drives the instruction-bus request,
// buffers one instruction for decode, and discards responses made stale by redirects.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [31:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus_4,
  output logic [31:0] out_instr,
  output logic        out_adel,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DISCARD = 2'd1,
    ST_HALT    = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic        pending_q, pending_d;
  logic        out_valid_q, out_valid_d;
  logic        out_adel_q, out_adel_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_instr_q, out_instr_d;

  logic        req;
  logic [31:0] addr;
  logic        consume;
  logic        aligned;

  // Bus handshake: a request (ireq_valid/ireq_addr) is held stable from the cycle it is
  // raised until the cycle iresp_data_ok is seen, which may be that same cycle.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_addr_d  = req_addr_q;
    out_valid_d = out_valid_q;
    out_adel_d  = out_adel_q;
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;

    consume = out_valid_q & ~stall;
    aligned = (pc_q[1:0] == 2'b00);
    req     = 1'b0;
    addr    = pc_q;

    case (state_q)
      ST_RUN:     req = aligned & (pending_q | ~out_valid_q | ~stall);
      ST_DISCARD: begin
        req  = 1'b1;
        addr = req_addr_q;
      end
      default:    req = 1'b0;
    endcase

    if (req) req_addr_d = addr;
    pending_d = req & ~iresp_data_ok;

    if (consume) out_valid_d = 1'b0;

    if (redirect_valid) begin
      pc_d        = redirect_pc;
      out_valid_d = 1'b0;
      state_d     = (req & ~iresp_data_ok) ? ST_DISCARD : ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (aligned) begin
            if (req & iresp_data_ok) begin
              out_valid_d = 1'b1;
              out_adel_d  = 1'b0;
              out_pc_d    = pc_q;
              out_instr_d = iresp_data;
              pc_d        = pc_q + 32'd4;
            end
          end else if (~out_valid_q | consume) begin
            // Misaligned PC becomes an address-error bubble; fetching stops until redirected.
            out_valid_d = 1'b1;
            out_adel_d  = 1'b1;
            out_pc_d    = pc_q;
            out_instr_d = 32'd0;
            state_d     = ST_HALT;
          end
        end
        ST_DISCARD: if (iresp_data_ok) state_d = ST_RUN;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN;
      pc_q        <= RESET_PC;
      req_addr_q  <= RESET_PC;
      pending_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_adel_q  <= 1'b0;
      out_pc_q    <= 32'd0;
      out_instr_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      out_adel_q  <= out_adel_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
    end
  end

  assign ireq_valid    = req & ~reset;
  assign ireq_addr     = addr;
  assign out_valid     = out_valid_q;
  assign out_pc        = out_pc_q;
  assign out_pc_plus_4 = out_pc_q + 32'd4;
  assign out_instr     = out_instr_q;
  assign out_adel      = out_adel_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios then randomized traffic, checked against a
// transaction-level model of the fetch buffer and instruction bus.
module tb_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus_4;
  logic [31:0] out_instr;
  logic        out_adel;
  logic [1:0]  state_dbg;

  fetch_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .ireq_valid    (ireq_valid),
    .ireq_addr     (ireq_addr),
    .iresp_data_ok (iresp_data_ok),
    .iresp_data    (iresp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .stall         (stall),
    .out_valid     (out_valid),
    .out_pc        (out_pc),
    .out_pc_plus_4 (out_pc_plus_4),
    .out_instr     (out_instr),
    .out_adel      (out_adel),
    .state_dbg     (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // expected delivered PCs (program order)
  logic [31:0] exp_q[$];

  // reference model state
  bit          m_valid;
  bit          m_adel;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_fetch_pc;
  bit          m_busy;
  bit          m_stale;
  logic [31:0] m_stale_addr;
  bit          m_halt;

  // bus responder state
  bit          rsp_active;
  logic [31:0] rsp_addr;
  int          rsp_cnt;
  int          lat;
  bit          rand_lat;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid    = 0;
    m_adel     = 0;
    m_pc       = 32'd0;
    m_instr    = 32'd0;
    m_fetch_pc = 32'hbfc0_0000;
    m_busy     = 0;
    m_stale    = 0;
    m_halt     = 0;
    rsp_active = 0;
    rsp_cnt    = 0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset          = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    iresp_data_ok  = 1'b0;
    #1;
    chk("rst_ireq_valid", ireq_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_adel", out_adel, 0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // One bus cycle: check registered outputs, drive inputs, respond, advance the model.
  task automatic cyc(input bit stl, input bit rv, input logic [31:0] rpc);
    bit          exp_req;
    logic [31:0] exp_addr;
    bit          ok;
    bit          take;
    @(negedge clk);
    chk("out_valid", out_valid, m_valid);
    if (m_valid) begin
      chk("out_pc", out_pc, m_pc);
      chk("out_instr", out_instr, m_instr);
      chk("out_adel", out_adel, m_adel);
      chk("out_pc_plus_4", out_pc_plus_4, m_pc + 32'd4);
    end
    stall          = stl;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
    exp_req  = !m_halt && (m_stale || (m_fetch_pc[1:0] == 2'b00 && (m_busy || !m_valid || !stl)));
    exp_addr = m_stale ? m_stale_addr : m_fetch_pc;
    chk("ireq_valid", ireq_valid, exp_req);
    if (exp_req && ireq_valid) chk("ireq_addr", ireq_addr, exp_addr);

    if (ireq_valid) begin
      if (rsp_active) chk("bus_hold_addr", ireq_addr, rsp_addr);
      else begin
        rsp_active = 1;
        rsp_addr   = ireq_addr;
        rsp_cnt    = rand_lat ? int'($urandom_range(0, 3)) : lat;
      end
      iresp_data_ok = (rsp_cnt == 0);
      iresp_data    = mem(rsp_addr);
    end else begin
      if (rsp_active) begin
        chk("bus_hold_valid", ireq_valid, 1);
        rsp_active = 0;
      end
      iresp_data_ok = 1'b0;
      iresp_data    = $urandom;
    end
    ok = iresp_data_ok;
    if (ok) rsp_active = 0;
    else if (rsp_active) rsp_cnt--;

    take = m_valid && !stl;
    if (take && !rv) begin
      if (exp_q.size() == 0) chk("deliver_empty", 1, 0);
      else chk("deliver_pc", out_pc, exp_q.pop_front());
    end

    if (rv) begin
      m_valid = 0;
      exp_q.delete();
      m_stale      = exp_req && !ok && (m_stale || 1'b1);
      m_stale_addr = exp_addr;
      m_fetch_pc   = rpc;
      m_busy       = 0;
      m_halt       = 0;
    end else if (m_stale) begin
      if (take) m_valid = 0;
      if (ok) m_stale = 0;
    end else if (m_halt) begin
      if (take) m_valid = 0;
    end else if (m_fetch_pc[1:0] != 2'b00) begin
      if (!m_valid || take) begin
        m_valid = 1; m_adel = 1; m_pc = m_fetch_pc; m_instr = 32'd0; m_halt = 1;
        exp_q.push_back(m_pc);
      end
    end else if (exp_req && ok) begin
      m_valid = 1; m_adel = 0; m_pc = m_fetch_pc; m_instr = mem(m_fetch_pc);
      exp_q.push_back(m_pc);
      m_fetch_pc = m_fetch_pc + 32'd4;
      m_busy     = 0;
    end else begin
      if (take) m_valid = 0;
      m_busy = exp_req;
    end
  endtask

  initial begin
    logic [31:0] rpc;
    bit          stl;
    bit          rv;
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    iresp_data_ok = 1'b0; iresp_data = 32'd0;
    lat = 0; rand_lat = 0;
    model_reset();

    // zero-wait stream
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 32'd0);
      @(posedge clk); #1;
      chk("zw_out_valid", out_valid, 1);
      chk("zw_out_pc", out_pc, 32'hbfc0_0000 + 32'(4 * i));
      chk("zw_pc_plus_4", out_pc_plus_4, 32'hbfc0_0004 + 32'(4 * i));
    end

    // wait states
    do_reset();
    lat = 3;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 32'd0);
      chk("ws_addr_held", ireq_addr, 32'hbfc0_0000);
      @(posedge clk); #1;
      chk("ws_not_yet", out_valid, 0);
    end
    cyc(0, 0, 32'd0);
    @(posedge clk); #1;
    chk("ws_out_valid", out_valid, 1);
    chk("ws_out_pc", out_pc, 32'hbfc0_0000);

    // stall with a full buffer
    do_reset();
    lat = 0;
    cyc(0, 0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 32'd0);
      chk("st_no_req", ireq_valid, 0);
      @(posedge clk); #1;
      chk("st_instr_held", out_instr, mem(32'hbfc0_0000));
    end
    cyc(0, 0, 32'd0);
    chk("st_resume_valid", ireq_valid, 1);
    chk("st_resume_addr", ireq_addr, 32'hbfc0_0004);

    // redirect with a request in flight
    do_reset();
    lat = 0;
    cyc(0, 0, 32'd0);
    lat = 2;
    cyc(0, 0, 32'd0);
    cyc(0, 1, 32'h8000_1000);
    chk("rf_addr_held0", ireq_addr, 32'hbfc0_0004);
    cyc(0, 0, 32'd0);
    chk("rf_addr_held1", ireq_addr, 32'hbfc0_0004);
    @(posedge clk); #1;
    chk("rf_dropped", out_valid, 0);
    lat = 0;
    cyc(0, 0, 32'd0);
    chk("rf_new_addr", ireq_addr, 32'h8000_1000);

    // redirect together with data_ok
    do_reset();
    lat = 0;
    cyc(0, 0, 32'd0);
    cyc(0, 1, 32'h8000_2000);
    @(posedge clk); #1;
    chk("rd_dropped", out_valid, 0);
    cyc(0, 0, 32'd0);
    chk("rd_new_addr", ireq_addr, 32'h8000_2000);

    // misaligned redirect target
    do_reset();
    lat = 0;
    cyc(0, 1, 32'h8000_0002);
    cyc(0, 0, 32'd0);
    chk("ma_no_req", ireq_valid, 0);
    @(posedge clk); #1;
    chk("ma_valid", out_valid, 1);
    chk("ma_adel", out_adel, 1);
    chk("ma_pc", out_pc, 32'h8000_0002);
    chk("ma_instr", out_instr, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 32'd0);
      chk("ma_halt_no_req", ireq_valid, 0);
    end
    cyc(0, 1, 32'h8000_0000);
    cyc(0, 0, 32'd0);
    chk("ma_resume_valid", ireq_valid, 1);
    chk("ma_resume_addr", ireq_addr, 32'h8000_0000);

    // randomized traffic
    do_reset();
    rand_lat = 1;
    for (int i = 0; i < 4000; i++) begin
      stl = ($urandom_range(0, 9) < 3);
      rv  = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 9))
        0:       rpc = ($urandom & 32'hffff_fffc) | 32'($urandom_range(1, 3));
        1:       rpc = 32'hffff_fff8;
        default: rpc = $urandom & 32'hffff_fffc;
      endcase
      if ($urandom_range(0, 499) == 0) do_reset();
      else cyc(stl, rv, rpc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
